hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_pkg.sv | 11 +
 rtl/sat_counter.sv | 34 +++
 rtl/hazard_controller.sv | 136 +++++++++++++
 tb/tb_hazard_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared FSM state encodings and the default mul/div watchdog limit for the hazard controller.
package hazard_pkg;

    localparam int MD_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MD_WAIT = 2'b01
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard control: load-use stall, branch flush and multi-cycle mul/div wait with watchdog.
// Outputs are combinational from state and inputs; stall/flush decisions take effect the same cycle.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT,
    parameter int CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_if_id_rs1,
    input  logic [4:0]       i_if_id_rs2,
    input  logic             i_if_id_uses_rs1,
    input  logic             i_if_id_uses_rs2,
    input  logic [4:0]       i_id_ex_rd,
    input  logic             i_id_ex_mem_read,
    input  logic             i_id_ex_md_op,
    input  logic             i_md_done,
    input  logic             i_ex_branch_taken,
    output logic             o_pc_write,
    output logic             o_if_id_write,
    output logic             o_if_id_flush,
    output logic             o_id_ex_flush,
    output logic             o_id_ex_hold,
    output logic             o_ex_mem_bubble,
    output logic             o_md_start,
    output logic             o_md_timeout,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cycles
);

    localparam int WD_W = $clog2(MD_TIMEOUT) + 1;

    state_e          state_q;
    state_e          state_d;
    logic            tmo_q;
    logic            tmo_set;
    logic            wd_clear;
    logic            wd_inc;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;
    logic            load_use;

    assign load_use = i_id_ex_mem_read && (i_id_ex_rd != 5'd0) &&
                      ((i_if_id_uses_rs1 && (i_id_ex_rd == i_if_id_rs1)) ||
                       (i_if_id_uses_rs2 && (i_id_ex_rd == i_if_id_rs2)));

    // Last permitted wait cycle: it behaves like a done cycle.
    assign wd_expired = (wd_cnt == WD_W'(MD_TIMEOUT - 1));

    always_comb begin
        state_d         = state_q;
        o_pc_write      = 1'b1;
        o_if_id_write   = 1'b1;
        o_if_id_flush   = 1'b0;
        o_id_ex_flush   = 1'b0;
        o_id_ex_hold    = 1'b0;
        o_ex_mem_bubble = 1'b0;
        o_md_start      = 1'b0;
        wd_clear        = 1'b0;
        wd_inc          = 1'b0;
        tmo_set         = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (i_ex_branch_taken) begin
                    o_if_id_flush = 1'b1;
                    o_id_ex_flush = 1'b1;
                end else if (i_id_ex_md_op) begin
                    o_md_start      = 1'b1;
                    o_pc_write      = 1'b0;
                    o_if_id_write   = 1'b0;
                    o_id_ex_hold    = 1'b1;
                    o_ex_mem_bubble = 1'b1;
                    wd_clear        = 1'b1;
                    state_d         = ST_MD_WAIT;
                end else if (load_use) begin
                    o_pc_write    = 1'b0;
                    o_if_id_write = 1'b0;
                    o_id_ex_flush = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                if (i_md_done || wd_expired) begin
                    tmo_set = !i_md_done;
                    state_d = ST_RUN;
                end else begin
                    o_pc_write      = 1'b0;
                    o_if_id_write   = 1'b0;
                    o_id_ex_hold    = 1'b1;
                    o_ex_mem_bubble = 1'b1;
                    wd_inc          = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (!i_rst_n) begin
            o_pc_write      = 1'b1;
            o_if_id_write   = 1'b1;
            o_if_id_flush   = 1'b0;
            o_id_ex_flush   = 1'b0;
            o_id_ex_hold    = 1'b0;
            o_ex_mem_bubble = 1'b0;
            o_md_start      = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_RUN;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_q | tmo_set;
        end
    end

    sat_counter #(.WIDTH(WD_W)) u_watchdog (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (wd_clear),
        .i_inc   (wd_inc),
        .o_count (wd_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (1'b0),
        .i_inc   (!o_pc_write),
        .o_count (o_stall_cycles)
    );

    assign o_state      = state_q;
    assign o_md_timeout = tmo_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized and directed bench for hazard_controller against a cycle-level behavioural model.
module tb_hazard_controller;

    localparam int TMO   = 8;
    localparam int CW    = 6;
    localparam int SATV  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    rs1, rs2, rd;
    logic          use1, use2, mem_rd, md_op, md_done, br;
    logic          pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, exmem_bubble;
    logic          md_start, md_timeout;
    logic [1:0]    state;
    logic [CW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit m_wait = 0;
    int m_wcnt = 0;
    bit m_tmo  = 0;
    int m_stalls = 0;

    always #5 clk = ~clk;

    hazard_controller #(.MD_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_if_id_rs1       (rs1),
        .i_if_id_rs2       (rs2),
        .i_if_id_uses_rs1  (use1),
        .i_if_id_uses_rs2  (use2),
        .i_id_ex_rd        (rd),
        .i_id_ex_mem_read  (mem_rd),
        .i_id_ex_md_op     (md_op),
        .i_md_done         (md_done),
        .i_ex_branch_taken (br),
        .o_pc_write        (pc_write),
        .o_if_id_write     (ifid_write),
        .o_if_id_flush     (ifid_flush),
        .o_id_ex_flush     (idex_flush),
        .o_id_ex_hold      (idex_hold),
        .o_ex_mem_bubble   (exmem_bubble),
        .o_md_start        (md_start),
        .o_md_timeout      (md_timeout),
        .o_state           (state),
        .o_stall_cycles    (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        use1 = 1'b0; use2 = 1'b0; mem_rd = 1'b0; md_op = 1'b0; md_done = 1'b0; br = 1'b0;
    endtask

    // Compare every output at the negedge against the model, then advance the model across the posedge.
    task automatic tick();
        bit luh, rel;
        bit e_pc, e_ifw, e_iff, e_idf, e_hold, e_bub, e_start;
        @(negedge clk);
        luh = mem_rd && rd != 0 && ((use1 && rd == rs1) || (use2 && rd == rs2));
        e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_hold = 0; e_bub = 0; e_start = 0;
        rel = 0;
        if (rst_n) begin
            if (!m_wait) begin
                if (br) begin
                    e_iff = 1; e_idf = 1;
                end else if (md_op) begin
                    e_start = 1; e_pc = 0; e_ifw = 0; e_hold = 1; e_bub = 1;
                end else if (luh) begin
                    e_pc = 0; e_ifw = 0; e_idf = 1;
                end
            end else begin
                rel = md_done || (m_wcnt == TMO - 1);
                if (!rel) begin
                    e_pc = 0; e_ifw = 0; e_hold = 1; e_bub = 1;
                end
            end
        end
        chk("ctrl", {pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, exmem_bubble, md_start},
            {e_pc, e_ifw, e_iff, e_idf, e_hold, e_bub, e_start});
        chk("state_tmo", {state, md_timeout}, {1'b0, m_wait, m_tmo});
        chk("stall_cnt", stall_cycles, m_stalls);
        if (!rst_n) begin
            m_wait = 0; m_wcnt = 0; m_tmo = 0; m_stalls = 0;
        end else begin
            if (!e_pc) m_stalls = (m_stalls < SATV) ? m_stalls + 1 : SATV;
            if (!m_wait) begin
                if (!br && md_op) begin
                    m_wait = 1; m_wcnt = 0;
                end
            end else if (rel) begin
                m_wait = 0;
                if (!md_done) m_tmo = 1;
            end else begin
                m_wcnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_state", state, 0);
        chk("rst_stalls", stall_cycles, 0);
        chk("rst_tmo", md_timeout, 0);
        chk("rst_pc", pc_write, 1);
        idle_inputs();

        // load x5 in EX, ID reads x5: one-cycle stall
        rd = 5'd5; mem_rd = 1'b1; rs1 = 5'd5; use1 = 1'b1;
        #1 chk("lu_pc", pc_write, 0);
        chk("lu_flush", idex_flush, 1);
        tick();
        idle_inputs();
        tick();
        chk("lu_pc_after", pc_write, 1);
        chk("lu_stalls", stall_cycles, 1);

        // load to x0 never stalls
        rd = 5'd0; mem_rd = 1'b1; rs1 = 5'd0; use1 = 1'b1;
        #1 chk("x0_pc", pc_write, 1);
        tick();

        // branch beats load-use
        rd = 5'd7; mem_rd = 1'b1; rs2 = 5'd7; use2 = 1'b1; br = 1'b1;
        #1 chk("br_flush", {ifid_flush, idex_flush, pc_write}, 3'b111);
        tick();
        idle_inputs();

        // mul/div with done on wait cycle index 5: start + 5 stalled wait cycles
        do_reset();
        md_op = 1'b1;
        #1 chk("md_start", md_start, 1);
        tick();
        md_op = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        md_done = 1'b1;
        #1 chk("md_done_pc", pc_write, 1);
        tick();
        md_done = 1'b0;
        chk("md_stalls", stall_cycles, 6);
        chk("md_state", state, 0);
        chk("md_no_tmo", md_timeout, 0);

        // watchdog release after TMO wait cycles, sticky flag
        do_reset();
        md_op = 1'b1;
        tick();
        md_op = 1'b0;
        for (int i = 0; i < TMO; i++) tick();
        chk("wd_state", state, 0);
        chk("wd_tmo", md_timeout, 1);
        chk("wd_stalls", stall_cycles, TMO);
        for (int i = 0; i < 4; i++) tick();
        chk("wd_sticky", md_timeout, 1);

        // reset in wait cycle 3 aborts the wait
        md_op = 1'b1;
        tick();
        md_op = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1 chk("rst_wait_pc", pc_write, 1);
        tick();
        rst_n = 1'b1;
        chk("rst_wait_state", state, 0);
        chk("rst_wait_stalls", stall_cycles, 0);
        chk("rst_wait_tmo", md_timeout, 0);
        #1 chk("rst_wait_nostart", md_start, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n   = ($urandom_range(0, 299) != 0);
            rs1     = 5'($urandom_range(0, 3));
            rs2     = 5'($urandom_range(0, 3));
            rd      = 5'($urandom_range(0, 3));
            use1    = 1'($urandom_range(0, 1));
            use2    = 1'($urandom_range(0, 1));
            mem_rd  = ($urandom_range(0, 9) < 4);
            md_op   = ($urandom_range(0, 9) == 0);
            md_done = ($urandom_range(0, 19) < 3);
            br      = ($urandom_range(0, 19) < 3);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
